// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Multicycle control FSM for the 16-bit CPU. It walks every instruction through
// fetch, PC update and decode, then through the execute/write-back/memory
// states that the instruction class needs. The instruction decoder alongside
// this block supplies register numbers, immediates and the asel/bsel/vsel
// selects. This block drives every load/write strobe and every memory command.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (returns the FSM to RST)
//   opcode     instruction[15:13] from the instruction register
//   op         instruction[12:11] from the instruction register
//   load_ir    instruction register load enable
//   load_pc    PC load enable
//   reset_pc   PC next-value select: 1 = zero, 0 = PC+1
//   addr_sel   memory address mux: 1 = PC, 0 = data address register
//   load_addr  data address register load enable
//   mem_cmd    memory command: 00 none, 01 read, 10 write
//   loada      A register load
//   loadb      B register load
//   loadc      C register load
//   loads      status register load
//   write      register-file write enable
//   halt       high while halted
//   state      current state encoding (debug only)
// -----------------------------------------------------------------------------
module cpu_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         opcode,
    input  logic [1:0]         op,
    output logic               load_ir,
    output logic               load_pc,
    output logic               reset_pc,
    output logic               addr_sel,
    output logic               load_addr,
    output logic [1:0]         mem_cmd,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               write,
    output logic               halt,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_RST       = 4'd0,
        S_IF1       = 4'd1,
        S_IF2       = 4'd2,
        S_UPDATE_PC = 4'd3,
        S_DECODE    = 4'd4,
        S_WRITE_IMM = 4'd5,
        S_GETA      = 4'd6,
        S_GETB      = 4'd7,
        S_EXEC      = 4'd8,
        S_WRITE_REG = 4'd9,
        S_MEM_ADDR  = 4'd10,
        S_MEM_RD1   = 4'd11,
        S_MEM_RD2   = 4'd12,
        S_MEM_WR    = 4'd13,
        S_HALT      = 4'd14
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  opcode_q;
    logic [1:0]  op_q;
    logic [2:0]  opcodeEff;
    logic [1:0]  opEff;

    logic        load_ir_d, load_pc_d, reset_pc_d, addr_sel_d, load_addr_d;
    logic [1:0]  mem_cmd_d;
    logic        loada_d, loadb_d, loadc_d, loads_d, write_d, halt_d;

    // The instruction fields are only trusted in DECODE; they are captured there
    // so that later states steer by the decoded instruction even if the IR
    // inputs wander afterwards.
    assign opcodeEff = (state_q == S_DECODE) ? opcode : opcode_q;
    assign opEff     = (state_q == S_DECODE) ? op     : op_q;

    // Next-state logic, followed by the output pattern of the state being
    // entered, so the outputs can be registered alongside the state and still
    // reflect the current state exactly.
    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:       state_d = S_IF1;
            S_IF1:       state_d = S_IF2;
            S_IF2:       state_d = S_UPDATE_PC;
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                if (opcodeEff == 3'b110 && opEff == 2'b10)      state_d = S_WRITE_IMM;
                else if (opcodeEff == 3'b110 && opEff == 2'b00) state_d = S_GETB;
                else if (opcodeEff == 3'b101)                   state_d = S_GETA;
                else if (opcodeEff == 3'b011 && opEff == 2'b00) state_d = S_GETA;
                else if (opcodeEff == 3'b100 && opEff == 2'b00) state_d = S_GETA;
                else if (opcodeEff == 3'b111)                   state_d = S_HALT;
                else                                            state_d = S_IF1;
            end
            S_WRITE_IMM: state_d = S_IF1;
            S_GETA: begin
                if (opcodeEff == 3'b101)                              state_d = S_GETB;
                else if (opcodeEff == 3'b011 || opcodeEff == 3'b100)  state_d = S_EXEC;
                else                                                  state_d = S_IF1;
            end
            S_GETB: begin
                if (opcodeEff == 3'b110 || opcodeEff == 3'b101) state_d = S_EXEC;
                else if (opcodeEff == 3'b100)                   state_d = S_MEM_WR;
                else                                            state_d = S_IF1;
            end
            S_EXEC: begin
                if (opcodeEff == 3'b110)                              state_d = S_WRITE_REG;
                else if (opcodeEff == 3'b101 && opEff == 2'b01)       state_d = S_IF1;
                else if (opcodeEff == 3'b101)                         state_d = S_WRITE_REG;
                else if (opcodeEff == 3'b011 || opcodeEff == 3'b100)  state_d = S_MEM_ADDR;
                else                                                  state_d = S_IF1;
            end
            S_WRITE_REG: state_d = S_IF1;
            S_MEM_ADDR: begin
                // STR revisits GETB to load Rd, which becomes the store data.
                if (opcodeEff == 3'b011)      state_d = S_MEM_RD1;
                else if (opcodeEff == 3'b100) state_d = S_GETB;
                else                          state_d = S_IF1;
            end
            S_MEM_RD1:   state_d = S_MEM_RD2;
            S_MEM_RD2:   state_d = S_IF1;
            S_MEM_WR:    state_d = S_IF1;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_RST;
        endcase

        load_ir_d   = 1'b0;
        load_pc_d   = 1'b0;
        reset_pc_d  = 1'b0;
        addr_sel_d  = 1'b0;
        load_addr_d = 1'b0;
        mem_cmd_d   = 2'b00;
        loada_d     = 1'b0;
        loadb_d     = 1'b0;
        loadc_d     = 1'b0;
        loads_d     = 1'b0;
        write_d     = 1'b0;
        halt_d      = 1'b0;
        case (state_d)
            S_RST: begin
                load_pc_d  = 1'b1;
                reset_pc_d = 1'b1;
            end
            S_IF1: begin
                addr_sel_d = 1'b1;
                mem_cmd_d  = 2'b01;
            end
            S_IF2: begin
                addr_sel_d = 1'b1;
                mem_cmd_d  = 2'b01;
                load_ir_d  = 1'b1;
            end
            S_UPDATE_PC: load_pc_d = 1'b1;
            S_WRITE_IMM: write_d   = 1'b1;
            S_GETA:      loada_d   = 1'b1;
            S_GETB:      loadb_d   = 1'b1;
            S_EXEC: begin
                // Only CMP updates the status flags.
                loadc_d = 1'b1;
                loads_d = (opcodeEff == 3'b101) && (opEff == 2'b01);
            end
            S_WRITE_REG: write_d     = 1'b1;
            S_MEM_ADDR:  load_addr_d = 1'b1;
            S_MEM_RD1:   mem_cmd_d   = 2'b01;
            S_MEM_RD2: begin
                mem_cmd_d = 2'b01;
                write_d   = 1'b1;
            end
            S_MEM_WR:    mem_cmd_d = 2'b10;
            S_HALT:      halt_d    = 1'b1;
            default: ;
        endcase
    end

    // State, captured instruction fields and registered outputs. Reset loads
    // the RST output pattern directly so the PC is cleared on the first edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RST;
            opcode_q  <= 3'b000;
            op_q      <= 2'b00;
            load_ir   <= 1'b0;
            load_pc   <= 1'b1;
            reset_pc  <= 1'b1;
            addr_sel  <= 1'b0;
            load_addr <= 1'b0;
            mem_cmd   <= 2'b00;
            loada     <= 1'b0;
            loadb     <= 1'b0;
            loadc     <= 1'b0;
            loads     <= 1'b0;
            write     <= 1'b0;
            halt      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
                op_q     <= op;
            end
            load_ir   <= load_ir_d;
            load_pc   <= load_pc_d;
            reset_pc  <= reset_pc_d;
            addr_sel  <= addr_sel_d;
            load_addr <= load_addr_d;
            mem_cmd   <= mem_cmd_d;
            loada     <= loada_d;
            loadb     <= loadb_d;
            loadc     <= loadc_d;
            loads     <= loads_d;
            write     <= write_d;
            halt      <= halt_d;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// Drives instruction fields into cpu_controller one instruction at a time. For
// each instruction a reference model lists the state path the instruction
// takes and the strobes each of those states must show; every per-cycle
// expectation goes into a queue that a separate monitor drains on the falling
// clock edge, comparing against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       loadIr;
        logic       loadPc;
        logic       resetPc;
        logic       addrSel;
        logic       loadAddr;
        logic [1:0] memCmd;
        logic       loadA;
        logic       loadB;
        logic       loadC;
        logic       loadS;
        logic       wr;
        logic       hlt;
    } outRec_t;

    // Instruction classes used by the stimulus generator.
    localparam int C_MOVI  = 0;
    localparam int C_MOVR  = 1;
    localparam int C_ADD   = 2;
    localparam int C_AND   = 3;
    localparam int C_MVN   = 4;
    localparam int C_CMP   = 5;
    localparam int C_LDR   = 6;
    localparam int C_STR   = 7;
    localparam int C_BR    = 8;
    localparam int C_UND   = 9;
    localparam int C_OTHER = 10;
    localparam int C_HALT  = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       loada, loadb, loadc, loads, write, halt;
    logic [3:0] stateOut;

    outRec_t expQ[$];
    int      seqQ[$];
    int      total = 0;
    int      bad   = 0;

    cpu_controller #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .op        (op),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .addr_sel  (addr_sel),
        .load_addr (load_addr),
        .mem_cmd   (mem_cmd),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .write     (write),
        .halt      (halt),
        .state     (stateOut)
    );

    always #5 clk = ~clk;

    // Strobe pattern each state must present; anything not named stays 0.
    function automatic outRec_t expOut(input int s, input bit isCmp);
        outRec_t r;
        r    = '0;
        r.st = 4'(s);
        case (s)
            0:  begin r.loadPc = 1'b1; r.resetPc = 1'b1; end
            1:  begin r.addrSel = 1'b1; r.memCmd = 2'b01; end
            2:  begin r.addrSel = 1'b1; r.memCmd = 2'b01; r.loadIr = 1'b1; end
            3:  r.loadPc = 1'b1;
            5:  r.wr = 1'b1;
            6:  r.loadA = 1'b1;
            7:  r.loadB = 1'b1;
            8:  begin r.loadC = 1'b1; r.loadS = isCmp; end
            9:  r.wr = 1'b1;
            10: r.loadAddr = 1'b1;
            11: r.memCmd = 2'b01;
            12: begin r.memCmd = 2'b01; r.wr = 1'b1; end
            13: r.memCmd = 2'b10;
            14: r.hlt = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    // Path from IF1 up to (not including) the next IF1 for each class.
    task automatic buildSeq(input int cls);
        seqQ = '{1, 2, 3, 4};
        case (cls)
            C_MOVI:                    seqQ = {seqQ, 5};
            C_MOVR:                    seqQ = {seqQ, 7, 8, 9};
            C_ADD, C_AND, C_MVN:       seqQ = {seqQ, 6, 7, 8, 9};
            C_CMP:                     seqQ = {seqQ, 6, 7, 8};
            C_LDR:                     seqQ = {seqQ, 6, 8, 10, 11, 12};
            C_STR:                     seqQ = {seqQ, 6, 8, 10, 7, 13};
            C_HALT:                    seqQ = {seqQ, 14};
            default: ;
        endcase
    endtask

    task automatic genInstr(input int cls, output logic [2:0] opc, output logic [1:0] o);
        int k;
        opc = 3'b000;
        o   = 2'($urandom_range(0, 3));
        case (cls)
            C_MOVI:  begin opc = 3'b110; o = 2'b10; end
            C_MOVR:  begin opc = 3'b110; o = 2'b00; end
            C_ADD:   begin opc = 3'b101; o = 2'b00; end
            C_CMP:   begin opc = 3'b101; o = 2'b01; end
            C_AND:   begin opc = 3'b101; o = 2'b10; end
            C_MVN:   begin opc = 3'b101; o = 2'b11; end
            C_LDR:   begin opc = 3'b011; o = 2'b00; end
            C_STR:   begin opc = 3'b100; o = 2'b00; end
            C_BR:    opc = 3'b001;
            C_UND:   begin opc = 3'b110; o = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11; end
            C_HALT:  opc = 3'b111;
            default: begin
                k = $urandom_range(0, 3);
                case (k)
                    0:       opc = 3'b000;
                    1:       opc = 3'b010;
                    2:       begin opc = 3'b011; o = 2'($urandom_range(1, 3)); end
                    default: begin opc = 3'b100; o = 2'($urandom_range(1, 3)); end
                endcase
            end
        endcase
    endtask

    // Holds reset for n cycles (n >= 2), releasing it in the last cycle; each
    // cycle must read as RST. Entered and left at 1 time unit after a rising edge.
    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            reset = (i != n - 1);
            expQ.push_back(expOut(0, 1'b0));
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one instruction starting in its IF1 cycle. The real fields are only
    // presented during DECODE; every other cycle sees random junk. With
    // abortInExec the instruction is cut off by an asynchronous reset in EXEC.
    task automatic applyStimulus(input int cls, input bit abortInExec, input int haltCycles);
        logic [2:0] opc;
        logic [1:0] o;
        int         n;
        genInstr(cls, opc, o);
        buildSeq(cls);
        n = seqQ.size();
        if (abortInExec) begin
            for (int i = 0; i < seqQ.size(); i++) begin
                if (seqQ[i] == 8) begin
                    n = i;
                    break;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            expQ.push_back(expOut(seqQ[i], cls == C_CMP));
        end
        for (int i = 0; i < n; i++) begin
            if (seqQ[i] == 4) begin
                opcode = opc;
                op     = o;
            end else begin
                opcode = 3'($urandom_range(0, 7));
                op     = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
        end
        if (cls == C_HALT) begin
            for (int i = 0; i < haltCycles; i++) begin
                expQ.push_back(expOut(14, 1'b0));
                opcode = 3'($urandom_range(0, 7));
                op     = 2'($urandom_range(0, 3));
                @(posedge clk);
                #1;
            end
            doReset(2);
        end
        if (abortInExec) begin
            doReset(3);
        end
    endtask

    // Compares one cycle's outputs against the expectation at the queue head.
    task automatic checkOutput(input outRec_t want);
        outRec_t got;
        got = {stateOut, load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd,
               loada, loadb, loadc, loads, write, halt};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL cycle-outputs t=%0t got state=%0d vec=%h want state=%0d vec=%h",
                     $time, got.st, got, want.st, want);
        end
    endtask

    // Monitor: pops one expectation per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int directed[$];
        int cls;
        int waitCycles;
        reset  = 1'b1;
        opcode = 3'b000;
        op     = 2'b00;
        @(posedge clk);
        #1;
        $display("[TB] reset and directed instructions");
        doReset(3);

        directed = '{C_MOVI, C_ADD, C_CMP, C_LDR, C_STR, C_BR, C_UND,
                     C_MOVR, C_AND, C_MVN, C_OTHER};
        foreach (directed[i]) begin
            applyStimulus(directed[i], 1'b0, 0);
        end

        $display("[TB] reset asserted during EXEC");
        applyStimulus(C_ADD, 1'b1, 0);
        applyStimulus(C_MOVI, 1'b0, 0);

        $display("[TB] randomized instruction stream");
        for (int i = 0; i < 60; i++) begin
            cls = $urandom_range(0, 11);
            applyStimulus(cls, 1'b0, 3 + $urandom_range(0, 5));
        end

        $display("[TB] halt hold and reset recovery");
        applyStimulus(C_HALT, 1'b0, 24);
        applyStimulus(C_LDR, 1'b0, 0);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Multicycle control FSM that consumes the opcode/op fields of the instruction register.
- Sequences fetch, PC update, register reads, ALU execute, register write-back and data-memory access for the 16-bit CPU.
- Sits downstream of the instruction register and alongside the instruction decoder: the decoder supplies register numbers, immediates, asel/bsel/vsel; this block supplies every load/write strobe and memory command.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  3  instruction[15:13] from the instruction register
- op  input  2  instruction[12:11] from the instruction register
- load_ir  output  1  instruction register load enable
- load_pc  output  1  PC load enable
- reset_pc  output  1  PC next-value select: 1 = zero, 0 = PC+1
- addr_sel  output  1  memory address mux: 1 = PC, 0 = data address register
- load_addr  output  1  data address register load enable (captures datapath C)
- mem_cmd  output  2  00 none, 01 read, 10 write
- loada  output  1  A register load
- loadb  output  1  B register load
- loadc  output  1  C register load
- loads  output  1  status register load
- write  output  1  register-file write enable
- halt  output  1  high while halted
- state  output  STATE_W  current state, debug only

Behaviour:
- Moore FSM; all outputs decode from the state register only. Every output not listed for a state is 0.
- Async reset forces state RST=0 immediately, including mid-instruction. In RST: reset_pc=1, load_pc=1; all else 0.
- State encodings (also the `state` output values): RST 0, IF1 1, IF2 2, UPDATE_PC 3, DECODE 4, WRITE_IMM 5, GETA 6, GETB 7, EXEC 8, WRITE_REG 9, MEM_ADDR 10, MEM_RD1 11, MEM_RD2 12, MEM_WR 13, HALT 14.
- RST -> IF1.
- IF1 (addr_sel=1, mem_cmd=01) -> IF2.
- IF2 (addr_sel=1, mem_cmd=01, load_ir=1) -> UPDATE_PC.
- UPDATE_PC (load_pc=1, reset_pc=0) -> DECODE.
- DECODE dispatch: opcode/op are sampled here only.
  - 110/10 -> WRITE_IMM
  - 110/00 -> GETB
  - 101/any -> GETA
  - 011/00 -> GETA
  - 100/00 -> GETA
  - 111/any -> HALT
  - all others, including 001 branches and undefined op -> IF1 (executed as NOP).
- WRITE_IMM (write=1) -> IF1.
- GETA (loada=1) -> GETB for opcode 101; -> EXEC for 011/100.
- GETB (loadb=1):
  - -> EXEC for opcode 110 and 101.
  - -> MEM_WR for opcode 100.
- EXEC (loadc=1; loads=1 only when opcode=101 and op=01):
  - -> WRITE_REG for 110, and for 101 with op≠01.
  - -> IF1 for CMP.
  - -> MEM_ADDR for 011/100.
- WRITE_REG (write=1) -> IF1.
- MEM_ADDR (load_addr=1):
  - -> MEM_RD1 for 011.
  - -> GETB for 100; GETB loads Rd because the decoder steers readnum2 for STR.
- MEM_RD1 (addr_sel=0, mem_cmd=01) -> MEM_RD2.
- MEM_RD2 (addr_sel=0, mem_cmd=01, write=1) -> IF1. The decoder's vsel selects memory data.
- MEM_WR (addr_sel=0, mem_cmd=10) -> IF1. Memory write data is the B register output (datapath wiring).
- HALT (halt=1) is absorbing; only reset leaves it.
- Cycles per instruction, IF1 to next IF1:
  - MOV imm 5
  - MOV reg 7
  - ADD/AND/MVN 8
  - CMP 7
  - LDR 9
  - STR 9
  - NOP 4
- Unreachable encodings (15) -> RST on next edge.
- opcode/op changing outside DECODE has no effect.

Test Plan:
- Assert reset mid-EXEC, release -> state=0 same cycle with reset_pc=load_pc=1; then states 1,2,3,4 on successive edges; load_ir high only in state 2.
- IR=MOV R1,#5 (opcode 110, op 10) -> DECODE, WRITE_IMM with write=1 one cycle, back to IF1 5 cycles after previous IF1.
- ADD (101/00) -> loada, loadb, loadc, write each asserted exactly one cycle in order; loads never high. CMP (101/01) -> loads=1 with loadc in EXEC, write never high, 7-cycle instruction.
- LDR (011/00) -> states 6,8,10,11,12; mem_cmd=01 with addr_sel=0 in 11 and 12; write=1 only in 12. STR (100/00) -> states 6,8,10,7,13; mem_cmd=10 only in 13; write never high.
- HALT (111) -> state 14, halt=1 held for 20+ cycles with opcode toggled randomly; no strobes assert. Reset returns to RST.
- Branch opcode 001 and undefined 110/01 -> DECODE then IF1 directly, no loada/loadb/loadc/write/mem write.
